// File: rtl/servo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : servo_pkg                                                  |
// | Purpose  : Shared control-byte layout and constants for servo PWM.    |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package servo_pkg;

    localparam int POS_W         = 8;
    localparam int SLEW_W        = 4;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_INV      = 1;
    localparam int CTRL_SLEW_LSB = 4;

    localparam logic [POS_W-1:0] c_pos_center = 8'h80;

    typedef struct packed {
        logic [SLEW_W-1:0] slew;
        logic [1:0]        rsvd;
        logic              inv;
        logic              en;
    } servo_ctrl_t;

endpackage : servo_pkg
`default_nettype wire

// File: rtl/servo_slew_limiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : servo_slew_limiter                                         |
// | Purpose  : One slew-limited step of the position toward the target,  |
// |            plus the pulse width for the stepped position.            |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module servo_slew_limiter
    import servo_pkg::*;
#(
    parameter int MIN_TICKS  = 1000,
    parameter int STEP_TICKS = 4,
    parameter int WIDTH_W    = 15
) (
    input  logic [POS_W-1:0]   cur_pos_i,
    input  logic [POS_W-1:0]   target_i,
    input  logic [SLEW_W-1:0]  slew_i,
    output logic [POS_W-1:0]   next_pos_o,
    output logic [WIDTH_W-1:0] width_o
);

    logic             w_up;
    logic [POS_W-1:0] w_dist;
    logic [POS_W-1:0] w_step;

    assign w_up   = (target_i > cur_pos_i);
    assign w_dist = w_up ? (target_i - cur_pos_i) : (cur_pos_i - target_i);
    assign w_step = {{(POS_W-SLEW_W){1'b0}}, slew_i};

    // Landing exactly on the target whenever it is within one step avoids overshoot.
    always_comb begin
        next_pos_o = target_i;
        if ((slew_i != '0) && (w_dist > w_step)) begin
            next_pos_o = w_up ? (cur_pos_i + w_step) : (cur_pos_i - w_step);
        end
    end

    assign width_o = WIDTH_W'(MIN_TICKS) + WIDTH_W'(next_pos_o) * WIDTH_W'(STEP_TICKS);

endmodule : servo_slew_limiter
`default_nettype wire

// File: rtl/servo_pwm_channel.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : servo_pwm_channel                                          |
// | Purpose  : Frame-synchronous servo pulse with enable, invert, slew    |
// |            limiting; optional write watchdog via SERVO_FAILSAFE_EN.  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int PERIOD_TICKS    = 20000,
    parameter int MIN_TICKS       = 1000,
    parameter int STEP_TICKS      = 4,
    parameter int FAILSAFE_FRAMES = 50
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [POS_W-1:0] pos_i,
    input  logic [7:0]       ctrl_i,
    input  logic             wr_stb_i,
    output logic             pwm_o,
    output logic             frame_o,
    output logic [POS_W-1:0] cur_pos_o,
    output logic             failsafe_o
);

    localparam int CNT_W = $clog2(PERIOD_TICKS);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PERIOD_TICKS - 1);

    if (MIN_TICKS + 255 * STEP_TICKS >= PERIOD_TICKS) begin : g_param_check
        $error("servo_pwm_channel: widest pulse does not fit in PERIOD_TICKS");
    end

    servo_ctrl_t      w_ctrl;
    logic             w_boundary;
    logic [POS_W-1:0] w_next_pos;
    logic [CNT_W-1:0] w_next_width;
    logic             w_fs_block;
    logic             w_en_next;
    logic             w_en_eff;
    logic             w_inv_eff;
    logic [CNT_W-1:0] w_width_eff;
    logic             w_active;
    logic             w_pwm_next;

    logic [CNT_W-1:0] r_cnt;
    logic [POS_W-1:0] r_cur_pos;
    logic [CNT_W-1:0] r_width;
    logic             r_en;
    logic             r_inv;
    logic             r_first;
    logic             r_pwm;
    logic             r_frame;

    assign w_ctrl     = servo_ctrl_t'(ctrl_i);
    assign w_boundary = (r_cnt == '0);

    servo_slew_limiter #(
        .MIN_TICKS  (MIN_TICKS),
        .STEP_TICKS (STEP_TICKS),
        .WIDTH_W    (CNT_W)
    ) u_slew (
        .cur_pos_i  (r_cur_pos),
        .target_i   (pos_i),
        .slew_i     (w_ctrl.slew),
        .next_pos_o (w_next_pos),
        .width_o    (w_next_width)
    );

`ifdef SERVO_FAILSAFE_EN
    localparam int FS_W = $clog2(FAILSAFE_FRAMES + 1);
    localparam logic [FS_W-1:0] c_fs_max  = FS_W'(FAILSAFE_FRAMES);
    localparam logic [FS_W-1:0] c_fs_trip = FS_W'(FAILSAFE_FRAMES - 1);

    logic [FS_W-1:0] r_frames;
    logic            r_failsafe;
    logic            w_trip;
    logic [1:0]      w_unused_rsvd;

    assign w_unused_rsvd = w_ctrl.rsvd;
    assign w_trip        = w_boundary & (r_frames == c_fs_trip);
    // A write landing on the boundary cycle wins over the watchdog.
    assign w_fs_block    = ~wr_stb_i & (r_failsafe | w_trip);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frames   <= '0;
            r_failsafe <= 1'b0;
        end else if (wr_stb_i) begin
            r_frames   <= '0;
            r_failsafe <= 1'b0;
        end else if (w_boundary) begin
            if (r_frames != c_fs_max) begin
                r_frames <= r_frames + 1'b1;
            end
            if (w_trip) begin
                r_failsafe <= 1'b1;
            end
        end
    end

    assign failsafe_o = r_failsafe;
`else
    logic w_unused_inputs;

    assign w_unused_inputs = ^{wr_stb_i, w_ctrl.rsvd};
    assign w_fs_block      = 1'b0;
    assign failsafe_o      = 1'b0;
`endif

    // Frame 0 after reset release always runs disabled.
    assign w_en_next   = w_ctrl.en & ~r_first & ~w_fs_block;

    // On the boundary cycle the freshly latched values already govern the output.
    assign w_en_eff    = w_boundary ? w_en_next    : r_en;
    assign w_inv_eff   = w_boundary ? w_ctrl.inv   : r_inv;
    assign w_width_eff = w_boundary ? w_next_width : r_width;
    assign w_active    = (r_cnt < w_width_eff);
    assign w_pwm_next  = w_en_eff ? (w_active ^ w_inv_eff) : w_inv_eff;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_cur_pos <= c_pos_center;
            r_width   <= '0;
            r_en      <= 1'b0;
            r_inv     <= 1'b0;
            r_first   <= 1'b1;
            r_pwm     <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_cnt   <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
            r_first <= 1'b0;
            r_frame <= w_boundary;
            r_pwm   <= w_pwm_next;
            if (w_boundary) begin
                r_cur_pos <= w_next_pos;
                r_width   <= w_next_width;
                r_en      <= w_en_next;
                r_inv     <= w_ctrl.inv;
            end
        end
    end

    assign pwm_o     = r_pwm;
    assign frame_o   = r_frame;
    assign cur_pos_o = r_cur_pos;

endmodule : servo_pwm_channel
`default_nettype wire

// File: tb/tb_servo_pwm_channel.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_servo_pwm_channel                                       |
// | Purpose  : Frame-level scoreboard bench for servo_pwm_channel.        |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_servo_pwm_channel;

    localparam int P  = 600;
    localparam int MN = 50;
    localparam int ST = 2;
    localparam int FS = 6;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] len;
        logic        first;
        logic [7:0]  edges;
        logic [7:0]  pos;
        logic        fs;
    } frm_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pos;
    logic [7:0] ctrl;
    logic       wr_stb;
    logic       pwm;
    logic       frame;
    logic [7:0] cur_pos;
    logic       fs;

    int errors = 0;
    int checks = 0;

    frm_t exp_q[$];
    frm_t got_q[$];

    logic [7:0] m_cur;
    bit         m_first;
    int         m_frames;
    bit         m_fs;

    servo_pwm_channel #(
        .PERIOD_TICKS    (P),
        .MIN_TICKS       (MN),
        .STEP_TICKS      (ST),
        .FAILSAFE_FRAMES (FS)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pos_i      (pos),
        .ctrl_i     (ctrl),
        .wr_stb_i   (wr_stb),
        .pwm_o      (pwm),
        .frame_o    (frame),
        .cur_pos_o  (cur_pos),
        .failsafe_o (fs)
    );

    always #5 clk = ~clk;

    // Frame monitor: one record per frame, closed when the next frame_o arrives.
    initial begin
        frm_t cur;
        logic prev;
        bit   started;
        started = 0;
        cur     = '0;
        prev    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                started = 0;
            end else if (frame) begin
                if (started) got_q.push_back(cur);
                cur.first = pwm;
                cur.pos   = cur_pos;
                cur.fs    = fs;
                cur.hi    = {15'd0, pwm};
                cur.len   = 16'd1;
                cur.edges = 8'd0;
                prev      = pwm;
                started   = 1;
            end else if (started) begin
                cur.len = cur.len + 16'd1;
                cur.hi  = cur.hi + {15'd0, pwm};
                if (pwm !== prev) cur.edges = cur.edges + 8'd1;
                prev = pwm;
            end
        end
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    function automatic string fmt(frm_t f);
        return $sformatf("hi=%0d len=%0d first=%b edges=%0d pos=%h fs=%b",
                         f.hi, f.len, f.first, f.edges, f.pos, f.fs);
    endfunction

    task automatic model_reset();
        m_cur    = 8'h80;
        m_first  = 1;
        m_frames = 0;
        m_fs     = 0;
        exp_q.delete();
    endtask

    // Expected frame for the next boundary, from the inputs currently driven.
    task automatic plan();
        frm_t e;
        int s, t, c, w;
        bit en, inv;
        s = int'(ctrl[7:4]);
        t = int'(pos);
        c = int'(m_cur);
        if (s == 0) c = t;
        else if (t > c) c = (t - c > s) ? c + s : t;
        else if (t < c) c = (c - t > s) ? c - s : t;
        m_cur = 8'(c);
`ifdef SERVO_FAILSAFE_EN
        if (m_frames != FS) m_frames++;
        if (m_frames == FS) m_fs = 1;
`endif
        en      = ctrl[0] && !m_first && !m_fs;
        inv     = ctrl[1];
        m_first = 0;
        w       = MN + c * ST;
        e.len   = 16'(P);
        e.pos   = m_cur;
        e.fs    = m_fs;
        if (en) begin
            e.first = ~inv;
            e.hi    = inv ? 16'(P - w) : 16'(w);
            e.edges = 8'd1;
        end else begin
            e.first = inv;
            e.hi    = inv ? 16'(P) : 16'd0;
            e.edges = 8'd0;
        end
        exp_q.push_back(e);
    endtask

    task automatic write_regs(input logic [7:0] p, input logic [7:0] c);
        @(negedge clk);
        pos    = p;
        ctrl   = c;
        wr_stb = 1'b1;
        @(negedge clk);
        wr_stb   = 1'b0;
        m_frames = 0;
        m_fs     = 0;
    endtask

    // Pops the oldest measured frame and its expectation; waits are bounded.
    task automatic collect(output frm_t g, output frm_t e, output bit ok);
        int n;
        n = 0;
        while (got_q.size() == 0 && n < 3 * P) begin
            @(negedge clk);
            n++;
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: no frame_o within %0d cycles, want one", 3 * P);
            g  = '0;
            ok = 0;
        end else begin
            g  = got_q.pop_front();
            ok = 1;
        end
    endtask

    task automatic test_reset();
        frm_t g, e;
        bit ok;
        rst_n  = 1'b0;
        pos    = 8'h40;
        ctrl   = 8'h00;
        wr_stb = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pwm !== 1'b0)       begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm); end
        checks++; if (frame !== 1'b0)     begin errors++; $display("FAIL reset_frame: got %b want 0", frame); end
        checks++; if (cur_pos !== 8'h80)  begin errors++; $display("FAIL reset_cur_pos: got %h want 80", cur_pos); end
        checks++; if (fs !== 1'b0)        begin errors++; $display("FAIL reset_failsafe: got %b want 0", fs); end
        model_reset();
        plan();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            plan();
            collect(g, e, ok);
            if (ok) begin
                checks++;
                if (g !== e) begin errors++; $display("FAIL reset_frame%0d: got %s want %s", i, fmt(g), fmt(e)); end
            end
        end
    endtask

    task automatic test_enable_sweep();
        frm_t g, e;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) write_regs(8'h00, 8'h01);
            if (i == 1) write_regs(8'hFF, 8'h01);
            plan();
            collect(g, e, ok);
            if (ok) begin
                checks++;
                if (g !== e) begin errors++; $display("FAIL sweep_frame%0d: got %s want %s", i, fmt(g), fmt(e)); end
            end
        end
    endtask

    task automatic test_midframe();
        frm_t g, e;
        bit ok;
        write_regs(8'h10, 8'h01);
        plan();
        collect(g, e, ok);
        repeat (250) @(negedge clk);
        write_regs(8'h20, 8'h01);
        for (int i = 0; i < 2; i++) begin
            plan();
            collect(g, e, ok);
            if (ok) begin
                checks++;
                if (g !== e) begin errors++; $display("FAIL midframe_frame%0d: got %s want %s", i, fmt(g), fmt(e)); end
            end
        end
    endtask

    task automatic test_slew();
        frm_t g, e;
        bit ok;
        write_regs(8'h80, 8'h01);
        plan();
        collect(g, e, ok);
        write_regs(8'h90, 8'h21);
        for (int i = 0; i < 11; i++) begin
            if (i == 9) write_regs(8'h8F, 8'h21);
            plan();
            collect(g, e, ok);
            if (ok) begin
                checks++;
                if (g !== e) begin errors++; $display("FAIL slew_frame%0d: got %s want %s", i, fmt(g), fmt(e)); end
            end
        end
    endtask

    task automatic test_invert();
        frm_t g, e;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) write_regs(8'h00, 8'h03);
            if (i == 2) write_regs(8'h00, 8'h02);
            plan();
            collect(g, e, ok);
            if (ok) begin
                checks++;
                if (g !== e) begin errors++; $display("FAIL invert_frame%0d: got %s want %s", i, fmt(g), fmt(e)); end
            end
        end
    endtask

    task automatic test_reset_midpulse();
        frm_t g, e;
        bit ok;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pwm !== 1'b0)      begin errors++; $display("FAIL midreset_pwm: got %b want 0", pwm); end
        checks++; if (cur_pos !== 8'h80) begin errors++; $display("FAIL midreset_cur_pos: got %h want 80", cur_pos); end
        @(negedge clk);
        pos  = 8'h20;
        ctrl = 8'h03;
        model_reset();
        plan();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            plan();
            collect(g, e, ok);
            if (ok) begin
                checks++;
                if (g !== e) begin errors++; $display("FAIL midreset_frame%0d: got %s want %s", i, fmt(g), fmt(e)); end
            end
        end
    endtask

    task automatic test_failsafe();
        frm_t g, e;
        bit ok;
        write_regs(8'h10, 8'h01);
        plan();
        collect(g, e, ok);
        for (int i = 0; i < FS + 2; i++) begin
            plan();
            collect(g, e, ok);
            if (ok) begin
                checks++;
                if (g !== e) begin errors++; $display("FAIL failsafe_frame%0d: got %s want %s", i, fmt(g), fmt(e)); end
            end
        end
        repeat (100) @(negedge clk);
        checks++;
        if (fs !== m_fs) begin errors++; $display("FAIL failsafe_level: got %b want %b", fs, m_fs); end
        write_regs(8'h10, 8'h01);
        checks++;
        if (fs !== 1'b0) begin errors++; $display("FAIL failsafe_clear: got %b want 0", fs); end
        for (int i = 0; i < 2; i++) begin
            plan();
            collect(g, e, ok);
            if (ok) begin
                checks++;
                if (g !== e) begin errors++; $display("FAIL resume_frame%0d: got %s want %s", i, fmt(g), fmt(e)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_enable_sweep();
        test_midframe();
        test_slew();
        test_invert();
        test_reset_midpulse();
        test_failsafe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_servo_pwm_channel
`default_nettype wire
